// File: rtl/nes_cart_pkg.sv
// Shared cartridge definitions: iNES header layout, loader state encoding
// and the power-of-two mask helper used when sizing ROM address windows.
package nes_cart_pkg;

  // "NES\x1A", byte i of the magic lives at bits [8*i +: 8]
  localparam logic [31:0] INES_MAGIC = 32'h1A53454E;

  localparam int unsigned HDR_MAGIC_LEN = 4;
  localparam int unsigned HDR_PRG_UNITS = 4;
  localparam int unsigned HDR_CHR_UNITS = 5;
  localparam int unsigned HDR_FLAGS6    = 6;
  localparam int unsigned HDR_FLAGS7    = 7;
  localparam int unsigned HDR_LAST      = 15;

  localparam int unsigned PRG_UNIT_SHIFT = 14;  // 16 KB units
  localparam int unsigned CHR_UNIT_SHIFT = 13;  // 8 KB units
  localparam int unsigned CHR_RAM_BYTES  = 8192;
  localparam int unsigned TRAINER_BYTES  = 512;
  localparam int unsigned TRAINER_BASE   = 32'h1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_TRAINER,
    ST_PRG,
    ST_CHR,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  // Smallest (2^k - 1) whose window holds 'size' bytes.
  function automatic logic [31:0] pow2_mask(input logic [31:0] size);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((m + 32'd1) < size) m = {m[30:0], 1'b1};
    end
    return m;
  endfunction

endpackage

// File: rtl/ines_loader.sv
// iNES image loader: parses the 16-byte header, then streams PRG and CHR
// payload bytes out as single-cycle write strobes into cartridge memories.
// Optional trainer support is enabled by defining INES_TRAINER_EN, which adds
// the prgram_we / prgram_wr_addr ports.
module ines_loader
  import nes_cart_pkg::*;
#(
  parameter int PRG_ROM_DEPTH = 17,
  parameter int CHR_ROM_DEPTH = 15,
  parameter int PRG_RAM_DEPTH = 13
) (
  input  logic                     clk_cpu,
  input  logic                     rst,
  input  logic                     start,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [7:0]               wr_data,
  output logic [PRG_ROM_DEPTH-1:0] prg_wr_addr,
  output logic                     prg_we,
  output logic [CHR_ROM_DEPTH-1:0] chr_wr_addr,
  output logic                     chr_we,
  output logic [7:0]               mapper_id,
  output logic                     mirrorv,
  output logic                     chr_ram,
  output logic                     prg_ram,
  output logic [PRG_ROM_DEPTH-1:0] prg_mask,
  output logic [CHR_ROM_DEPTH-1:0] chr_mask,
  output logic [PRG_RAM_DEPTH-1:0] prgram_mask,
  output logic                     busy,
  output logic                     done,
  output logic                     error
`ifdef INES_TRAINER_EN
  ,
  output logic                     prgram_we,
  output logic [PRG_RAM_DEPTH-1:0] prgram_wr_addr
`endif
);

  localparam int unsigned CNT_W0 = (PRG_ROM_DEPTH > CHR_ROM_DEPTH) ? PRG_ROM_DEPTH : CHR_ROM_DEPTH;
  localparam int unsigned CNT_W  = (CNT_W0 > 10) ? CNT_W0 : 10;

  loader_state_t    state, state_next;
  logic [CNT_W-1:0] count;
  logic [31:0]      count_ext;
  logic [7:0]       prg_units;
  logic [7:0]       chr_units;
  logic             trainer;
  logic             acc;
  logic [31:0]      prg_total;
  logic [31:0]      chr_total;
  logic             hdr_last;
  logic             hdr_bad_magic;
  logic             hdr_invalid;
  logic             prg_last;
  logic             chr_last;
`ifdef INES_TRAINER_EN
  logic             trn_last;
`endif

  assign in_ready  = (state == ST_HEADER) || (state == ST_TRAINER) ||
                     (state == ST_PRG)    || (state == ST_CHR);
  assign busy      = in_ready;
  assign done      = (state == ST_DONE);
  assign error     = (state == ST_ERROR);
  assign acc       = in_valid && in_ready;
  assign count_ext = 32'(count);
  assign prg_total = 32'(prg_units) << PRG_UNIT_SHIFT;
  assign chr_total = 32'(chr_units) << CHR_UNIT_SHIFT;

  assign hdr_last      = (count_ext == HDR_LAST);
  assign hdr_bad_magic = (count_ext < HDR_MAGIC_LEN) &&
                         (in_data != INES_MAGIC[{count[1:0], 3'b000} +: 8]);
`ifdef INES_TRAINER_EN
  assign hdr_invalid   = (prg_units == 8'd0) ||
                         (prg_total > (32'd1 << PRG_ROM_DEPTH)) ||
                         (chr_total > (32'd1 << CHR_ROM_DEPTH));
  assign trn_last      = (count_ext == TRAINER_BYTES - 1);
`else
  assign hdr_invalid   = (prg_units == 8'd0) ||
                         (prg_total > (32'd1 << PRG_ROM_DEPTH)) ||
                         (chr_total > (32'd1 << CHR_ROM_DEPTH)) ||
                         trainer;
`endif
  assign prg_last      = (count_ext == prg_total - 32'd1);
  assign chr_last      = (count_ext == chr_total - 32'd1);

  // State register.
  always_ff @(posedge clk_cpu) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state: header validation and payload phase sequencing.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) state_next = ST_HEADER;
      end
      ST_HEADER: begin
        if (acc) begin
          if (hdr_bad_magic)    state_next = ST_ERROR;
          else if (hdr_last)    state_next = hdr_invalid ? ST_ERROR :
                                             (trainer ? ST_TRAINER : ST_PRG);
        end
      end
      ST_TRAINER: begin
`ifdef INES_TRAINER_EN
        if (acc && trn_last) state_next = ST_PRG;
`else
        state_next = ST_ERROR;
`endif
      end
      ST_PRG: begin
        if (acc && prg_last) state_next = chr_ram ? ST_DONE : ST_CHR;
      end
      ST_CHR: begin
        if (acc && chr_last) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: header field capture, byte counter and registered write strobes.
  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      count       <= '0;
      prg_units   <= '0;
      chr_units   <= '0;
      trainer     <= 1'b0;
      mapper_id   <= '0;
      mirrorv     <= 1'b0;
      prg_ram     <= 1'b0;
      chr_ram     <= 1'b0;
      prg_mask    <= '0;
      chr_mask    <= '0;
      prgram_mask <= '0;
      wr_data     <= '0;
      prg_wr_addr <= '0;
      prg_we      <= 1'b0;
      chr_wr_addr <= '0;
      chr_we      <= 1'b0;
`ifdef INES_TRAINER_EN
      prgram_we      <= 1'b0;
      prgram_wr_addr <= '0;
`endif
    end else begin
      prg_we <= 1'b0;
      chr_we <= 1'b0;
`ifdef INES_TRAINER_EN
      prgram_we <= 1'b0;
`endif
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            count       <= '0;
            prg_units   <= '0;
            chr_units   <= '0;
            trainer     <= 1'b0;
            mapper_id   <= '0;
            mirrorv     <= 1'b0;
            prg_ram     <= 1'b0;
            chr_ram     <= 1'b0;
            prg_mask    <= '0;
            chr_mask    <= '0;
            prgram_mask <= '0;
          end
        end
        ST_HEADER: begin
          if (acc) begin
            count <= count + 1'b1;
            case (count_ext)
              HDR_PRG_UNITS: prg_units <= in_data;
              HDR_CHR_UNITS: chr_units <= in_data;
              HDR_FLAGS6: begin
                mirrorv        <= in_data[0];
                prg_ram        <= in_data[1];
                trainer        <= in_data[2];
                mapper_id[3:0] <= in_data[7:4];
              end
              HDR_FLAGS7: mapper_id[7:4] <= in_data[7:4];
              HDR_LAST: begin
                count       <= '0;
                prg_mask    <= PRG_ROM_DEPTH'(pow2_mask(prg_total));
                chr_mask    <= (chr_units == 8'd0) ? CHR_ROM_DEPTH'(CHR_RAM_BYTES - 1)
                                                   : CHR_ROM_DEPTH'(pow2_mask(chr_total));
                prgram_mask <= '1;
                chr_ram     <= (chr_units == 8'd0);
              end
              default: ;
            endcase
          end
        end
`ifdef INES_TRAINER_EN
        ST_TRAINER: begin
          if (acc) begin
            prgram_we      <= 1'b1;
            prgram_wr_addr <= PRG_RAM_DEPTH'(TRAINER_BASE + count_ext);
            wr_data        <= in_data;
            count          <= trn_last ? '0 : count + 1'b1;
          end
        end
`endif
        ST_PRG: begin
          if (acc) begin
            prg_we      <= 1'b1;
            prg_wr_addr <= count[PRG_ROM_DEPTH-1:0];
            wr_data     <= in_data;
            count       <= prg_last ? '0 : count + 1'b1;
          end
        end
        ST_CHR: begin
          if (acc) begin
            chr_we      <= 1'b1;
            chr_wr_addr <= count[CHR_ROM_DEPTH-1:0];
            wr_data     <= in_data;
            count       <= chr_last ? '0 : count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ines_loader.sv
// Directed bench for ines_loader (default parameters). Trainer scenario adapts
// to INES_TRAINER_EN. A negedge monitor tallies strobes and checks that write
// addresses run 0,1,2,... with the data pattern the stimulus drove.
module tb_ines_loader;

  logic        clk_cpu = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  wr_data;
  logic [16:0] prg_wr_addr;
  logic        prg_we;
  logic [14:0] chr_wr_addr;
  logic        chr_we;
  logic [7:0]  mapper_id;
  logic        mirrorv, chr_ram, prg_ram;
  logic [16:0] prg_mask;
  logic [14:0] chr_mask;
  logic [12:0] prgram_mask;
  logic        busy, done, error;
`ifdef INES_TRAINER_EN
  logic        prgram_we;
  logic [12:0] prgram_wr_addr;
`endif

  ines_loader #(.PRG_ROM_DEPTH(17), .CHR_ROM_DEPTH(15), .PRG_RAM_DEPTH(13)) dut (
    .clk_cpu(clk_cpu), .rst(rst), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .wr_data(wr_data),
    .prg_wr_addr(prg_wr_addr), .prg_we(prg_we), .chr_wr_addr(chr_wr_addr),
    .chr_we(chr_we), .mapper_id(mapper_id), .mirrorv(mirrorv),
    .chr_ram(chr_ram), .prg_ram(prg_ram), .prg_mask(prg_mask),
    .chr_mask(chr_mask), .prgram_mask(prgram_mask), .busy(busy),
    .done(done), .error(error)
`ifdef INES_TRAINER_EN
    , .prgram_we(prgram_we), .prgram_wr_addr(prgram_wr_addr)
`endif
  );

  always #5 clk_cpu = ~clk_cpu;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  function automatic logic [7:0] pat(input int unsigned n);
    return 8'((n * 13) ^ (n >> 8));
  endfunction

  // Monitor state
  logic        mon_clr = 1'b0;
  int unsigned prg_n = 0, chr_n = 0, trn_n = 0;
  int unsigned prg_seq_bad = 0, chr_seq_bad = 0, trn_seq_bad = 0;
  logic [16:0] last_prg = '0;
  logic [14:0] last_chr = '0;
  logic [12:0] first_trn = '0, last_trn = '0;
  logic        done_d = 1'b0, done_strobe = 1'b0;

  // Strobe monitor sampled on the inactive edge.
  always @(negedge clk_cpu) begin
    if (mon_clr) begin
      prg_n = 0; chr_n = 0; trn_n = 0;
      prg_seq_bad = 0; chr_seq_bad = 0; trn_seq_bad = 0;
      last_prg = '0; last_chr = '0; first_trn = '0; last_trn = '0;
      done_d = 1'b0; done_strobe = 1'b0;
    end else begin
      if (prg_we === 1'b1) begin
        if (prg_wr_addr !== 17'(prg_n) || wr_data !== pat(prg_n)) prg_seq_bad++;
        last_prg = prg_wr_addr;
        prg_n++;
      end
      if (chr_we === 1'b1) begin
        if (chr_wr_addr !== 15'(chr_n) || wr_data !== pat(chr_n + 7)) chr_seq_bad++;
        last_chr = chr_wr_addr;
        chr_n++;
      end
`ifdef INES_TRAINER_EN
      if (prgram_we === 1'b1) begin
        if (prgram_wr_addr !== 13'(32'h1000 + trn_n) || wr_data !== pat(trn_n + 3)) trn_seq_bad++;
        if (trn_n == 0) first_trn = prgram_wr_addr;
        last_trn = prgram_wr_addr;
        trn_n++;
      end
`endif
      if (done === 1'b1 && done_d === 1'b0) done_strobe = prg_we | chr_we;
      done_d = done;
    end
  end

  task automatic push(input logic [7:0] b);
    @(negedge clk_cpu);
    in_data  = b;
    in_valid = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk_cpu);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic clear_mon();
    @(posedge clk_cpu);
    mon_clr = 1'b1;
    @(posedge clk_cpu);
    mon_clr = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk_cpu);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk_cpu);
    rst = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk_cpu);
    start = 1'b1;
    @(negedge clk_cpu);
    start = 1'b0;
  endtask

  task automatic send_header(input logic [7:0] b4, input logic [7:0] b5,
                             input logic [7:0] b6, input logic [7:0] b7);
    push(8'h4E); push(8'h45); push(8'h53); push(8'h1A);
    push(b4); push(b5); push(b6); push(b7);
    for (int i = 0; i < 8; i++) push(8'h00);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_cpu);
    n_cmp++; if ({in_ready, busy, done, error, prg_we, chr_we, mapper_id, prg_mask, chr_mask, prgram_mask,
                  prg_wr_addr, chr_wr_addr, wr_data, mirrorv, chr_ram, prg_ram} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got busy=%b rdy=%b map=%h pm=%h cm=%h want all 0",
                        busy, in_ready, mapper_id, prg_mask, chr_mask); end
    rst = 1'b0;
  endtask

  task automatic test_nrom_load();
    clear_mon();
    do_start();
    send_header(8'h02, 8'h01, 8'h01, 8'h00);
    idle();
    n_cmp++; if (mapper_id !== 8'h00) begin n_bad++; $display("FAIL nrom_mapper: got %h want 00", mapper_id); end
    n_cmp++; if (mirrorv !== 1'b1) begin n_bad++; $display("FAIL nrom_mirrorv: got %b want 1", mirrorv); end
    n_cmp++; if (prg_mask !== 17'h07FFF) begin n_bad++; $display("FAIL nrom_prg_mask: got %h want 07fff", prg_mask); end
    n_cmp++; if (chr_mask !== 15'h1FFF) begin n_bad++; $display("FAIL nrom_chr_mask: got %h want 1fff", chr_mask); end
    n_cmp++; if (chr_ram !== 1'b0) begin n_bad++; $display("FAIL nrom_chr_ram: got %b want 0", chr_ram); end
    n_cmp++; if (prgram_mask !== 13'h1FFF) begin n_bad++; $display("FAIL nrom_prgram_mask: got %h want 1fff", prgram_mask); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL nrom_busy_hdr: got %b want 1", busy); end
    for (int i = 0; i < 32768; i++) push(pat(i));
    for (int i = 0; i < 8192; i++) push(pat(i + 7));
    idle();
    idle();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL nrom_done: got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0 || error !== 1'b0 || in_ready !== 1'b0) begin n_bad++;
      $display("FAIL nrom_flags: got busy=%b err=%b rdy=%b want 0 0 0", busy, error, in_ready); end
    n_cmp++; if (prg_n !== 32768) begin n_bad++; $display("FAIL nrom_prg_count: got %0d want 32768", prg_n); end
    n_cmp++; if (prg_seq_bad !== 0) begin n_bad++; $display("FAIL nrom_prg_seq: got %0d bad want 0", prg_seq_bad); end
    n_cmp++; if (last_prg !== 17'h07FFF) begin n_bad++; $display("FAIL nrom_last_prg: got %h want 07fff", last_prg); end
    n_cmp++; if (chr_n !== 8192) begin n_bad++; $display("FAIL nrom_chr_count: got %0d want 8192", chr_n); end
    n_cmp++; if (chr_seq_bad !== 0) begin n_bad++; $display("FAIL nrom_chr_seq: got %0d bad want 0", chr_seq_bad); end
    n_cmp++; if (last_chr !== 15'h1FFF) begin n_bad++; $display("FAIL nrom_last_chr: got %h want 1fff", last_chr); end
    n_cmp++; if (done_strobe !== 1'b1) begin n_bad++; $display("FAIL nrom_done_strobe: got %b want 1", done_strobe); end
    n_cmp++; if (mirrorv !== 1'b1) begin n_bad++; $display("FAIL nrom_hold_mirrorv: got %b want 1", mirrorv); end
  endtask

  // Restart straight from DONE with a full-size (8 x 16 KB) mapper 2 header.
  task automatic test_restart_mapper2_hdr();
    do_start();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin n_bad++;
      $display("FAIL restart_from_done: got done=%b busy=%b want 0 1", done, busy); end
    send_header(8'h08, 8'h00, 8'h20, 8'h00);
    idle();
    n_cmp++; if (mapper_id !== 8'h02) begin n_bad++; $display("FAIL m2big_mapper: got %h want 02", mapper_id); end
    n_cmp++; if (prg_mask !== 17'h1FFFF) begin n_bad++; $display("FAIL m2big_prg_mask: got %h want 1ffff", prg_mask); end
    n_cmp++; if (error !== 1'b0 || busy !== 1'b1) begin n_bad++;
      $display("FAIL m2big_accept: got err=%b busy=%b want 0 1", error, busy); end
    apply_reset();
  endtask

  task automatic test_mapper2_load();
    clear_mon();
    do_start();
    send_header(8'h02, 8'h00, 8'h20, 8'h00);
    idle();
    n_cmp++; if (chr_ram !== 1'b1) begin n_bad++; $display("FAIL m2_chr_ram: got %b want 1", chr_ram); end
    n_cmp++; if (chr_mask !== 15'h1FFF) begin n_bad++; $display("FAIL m2_chr_mask: got %h want 1fff", chr_mask); end
    for (int i = 0; i < 32767; i++) push(pat(i));
    idle();
    idle();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin n_bad++;
      $display("FAIL m2_early_done: got done=%b busy=%b want 0 1", done, busy); end
    push(pat(32767));
    idle();
    idle();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL m2_done: got %b want 1", done); end
    n_cmp++; if (prg_n !== 32768 || prg_seq_bad !== 0) begin n_bad++;
      $display("FAIL m2_prg: got count=%0d bad=%0d want 32768 0", prg_n, prg_seq_bad); end
    n_cmp++; if (chr_n !== 0) begin n_bad++; $display("FAIL m2_no_chr_we: got %0d want 0", chr_n); end
    n_cmp++; if (mapper_id !== 8'h02) begin n_bad++; $display("FAIL m2_mapper_hold: got %h want 02", mapper_id); end
    n_cmp++; if (done_strobe !== 1'b1) begin n_bad++; $display("FAIL m2_done_strobe: got %b want 1", done_strobe); end
  endtask

  task automatic test_bad_magic();
    apply_reset();
    clear_mon();
    do_start();
    push(8'h4E); push(8'h45); push(8'h54);
    idle();
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL magic_error: got %b want 1", error); end
    n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b0) begin n_bad++;
      $display("FAIL magic_ready: got rdy=%b busy=%b want 0 0", in_ready, busy); end
    push(8'h1A); push(8'h02); push(8'h01);
    idle();
    idle();
    n_cmp++; if (prg_n + chr_n !== 0) begin n_bad++; $display("FAIL magic_no_strobe: got %0d want 0", prg_n + chr_n); end
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL magic_error_hold: got %b want 1", error); end
  endtask

  task automatic test_prg_units();
    do_start();
    n_cmp++; if (error !== 1'b0 || busy !== 1'b1) begin n_bad++;
      $display("FAIL restart_from_error: got err=%b busy=%b want 0 1", error, busy); end
    send_header(8'h03, 8'h01, 8'h00, 8'h00);
    idle();
    n_cmp++; if (prg_mask !== 17'h0FFFF) begin n_bad++; $display("FAIL units3_mask: got %h want 0ffff", prg_mask); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL units3_error: got %b want 0", error); end
    apply_reset();
    do_start();
    send_header(8'h09, 8'h01, 8'h00, 8'h00);
    idle();
    n_cmp++; if (error !== 1'b1 || busy !== 1'b0) begin n_bad++;
      $display("FAIL units9_error: got err=%b busy=%b want 1 0", error, busy); end
    apply_reset();
    do_start();
    send_header(8'h00, 8'h01, 8'h00, 8'h00);
    idle();
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL units0_error: got %b want 1", error); end
  endtask

  task automatic test_trainer();
    apply_reset();
    clear_mon();
    do_start();
    send_header(8'h01, 8'h00, 8'h04, 8'h00);
    idle();
`ifdef INES_TRAINER_EN
    n_cmp++; if (error !== 1'b0 || busy !== 1'b1) begin n_bad++;
      $display("FAIL trn_accept: got err=%b busy=%b want 0 1", error, busy); end
    for (int i = 0; i < 512; i++) push(pat(i + 3));
    idle();
    idle();
    n_cmp++; if (trn_n !== 512 || trn_seq_bad !== 0) begin n_bad++;
      $display("FAIL trn_writes: got count=%0d bad=%0d want 512 0", trn_n, trn_seq_bad); end
    n_cmp++; if (first_trn !== 13'h1000 || last_trn !== 13'h11FF) begin n_bad++;
      $display("FAIL trn_range: got %h..%h want 1000..11ff", first_trn, last_trn); end
    push(pat(0)); push(pat(1));
    idle();
    idle();
    n_cmp++; if (prg_n !== 2 || prg_seq_bad !== 0) begin n_bad++;
      $display("FAIL trn_then_prg: got count=%0d bad=%0d want 2 0", prg_n, prg_seq_bad); end
`else
    n_cmp++; if (error !== 1'b1 || busy !== 1'b0) begin n_bad++;
      $display("FAIL trn_reject: got err=%b busy=%b want 1 0", error, busy); end
`endif
  endtask

  task automatic test_gap_and_reset();
    apply_reset();
    clear_mon();
    do_start();
    send_header(8'h01, 8'h01, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) begin
      push(pat(i));
      idle();
    end
    idle();
    n_cmp++; if (prg_n !== 10 || prg_seq_bad !== 0) begin n_bad++;
      $display("FAIL gap_strobes: got count=%0d bad=%0d want 10 0", prg_n, prg_seq_bad); end
    push(pat(10)); push(pat(11)); push(pat(12));
    @(negedge clk_cpu);
    rst = 1'b1;
    @(negedge clk_cpu);
    n_cmp++; if ({in_ready, busy, done, error, prg_we, chr_we, mapper_id, prg_mask, chr_mask, prgram_mask,
                  prg_wr_addr, wr_data} !== '0) begin
      n_bad++; $display("FAIL midload_reset_outputs: got rdy=%b busy=%b we=%b pm=%h addr=%h want all 0",
                        in_ready, busy, prg_we, prg_mask, prg_wr_addr); end
    rst = 1'b0;
    repeat (3) @(negedge clk_cpu);
    in_valid = 1'b0;
    @(negedge clk_cpu);
    n_cmp++; if (prg_n !== 13 || prg_seq_bad !== 0) begin n_bad++;
      $display("FAIL midload_reset_strobes: got count=%0d bad=%0d want 13 0", prg_n, prg_seq_bad); end
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b0) begin n_bad++;
      $display("FAIL post_reset_idle: got busy=%b rdy=%b want 0 0", busy, in_ready); end
  endtask

  initial begin
    test_reset();
    test_nrom_load();
    test_restart_mapper2_hdr();
    test_mapper2_load();
    test_bad_magic();
    test_prg_units();
    test_trainer();
    test_gap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
